regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file for the CPU decode stage with N asynchronous read ports, one synchronous write port, optional same-cycle write-to-read bypass and a per-register pending scoreboard for multi-cycle results such as loads. It sits between the instruction decoder, which supplies the read and reserve addresses, and the write-back mux, which supplies the write port. It replaces the single-cycle 32×32 file. Reset clears the registers through a sequential sweep rather than a one-cycle clear.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_READ, 2, number of read ports (≥1)
- BYPASS, 1, 1 = a read of the register being written returns wr_data in the same cycle
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_READ*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_READ*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_READ  port k's register is pending
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- rsv_en  in  1  mark rsv_addr pending
- rsv_addr  in  ADDR_W  index to reserve
- ready  out  1  clear sweep done, file accepting writes and reserves
- pend_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- FSM with states CLEAR and RUN.
- While reset is high: state = CLEAR, sweep pointer = 0, all pending bits = 0, pend_cnt = 0.
- In CLEAR with reset low, each cycle writes 0 to reg[ptr] and increments ptr. The cycle that writes index 2**ADDR_W−1 moves the FSM to RUN.
- In CLEAR, wr_en and rsv_en are ignored. rd_data reads 0 on every port and rd_busy reads 0. ready = 0.
- In RUN, ready = 1.
- Write: when wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data at the edge and pending[wr_addr] is cleared.
- Reserve: when rsv_en=1 and rsv_addr≠0, pending[rsv_addr] is set at the edge.
- Write and reserve to the same address in the same cycle: data is written and the pending bit ends set, so the reserve wins.
- Register 0 always reads 0 and is never pending. Writes and reserves to index 0 are no-ops.
- Reads are combinational. rd_data[k] = reg[rd_addr[k]].
  - BYPASS=1 and wr_en=1 and wr_addr=rd_addr[k]≠0: rd_data[k] = wr_data.
- rd_busy[k] = pending[rd_addr[k]].
  - BYPASS=1: a write to that address in the same cycle forces rd_busy[k]=0, unless a same-address reserve is also present.
- pend_cnt counts set bits after each edge. Update rule per edge: +1 if a reserve sets a clear bit, −1 if a write clears a set bit, net 0 for reserve and write to the same already-pending address. It never exceeds 2**ADDR_W−1.

## Timing
- Reset values: ready=0, pend_cnt=0, rd_busy=0, rd_data=0.
- The clear sweep takes exactly 2**ADDR_W cycles after reset is released. ready rises on the edge after the last sweep write (edge 32 for ADDR_W=5).
- Write latency is 1 edge. Without bypass, a read of the written address in the same cycle returns the old value.
- Read latency is 0 cycles (combinational).
- Reset asserted mid-RUN or mid-CLEAR: on the next edge, state = CLEAR, ptr = 0, pending and pend_cnt are cleared, and the sweep restarts.

## Structure
- Package regfile_sb_pkg:
  - state enum {CLEAR, RUN}
  - default width constants
  - helper function for the flattened-port slice offsets
- Sub-module rf_scoreboard: holds the pending bit vector, the reserve/write priority logic and pend_cnt, and is cleared by reset.
- The top level holds the storage array, the sweep FSM/pointer and the read/bypass muxes, generated per port.

## Test plan
- Reset, then release: ready stays 0 for 32 cycles and rises on edge 32. All ports read 0 during the sweep.
- In RUN: write 0xDEADBEEF to r5, then read r5 on both ports next cycle → 0xDEADBEEF. Write to r0 → r0 still reads 0.
- BYPASS=1: write 0x12345678 to r7 while port 1 reads r7 → rd_data[1] = 0x12345678 in the same cycle. With BYPASS=0 → old value, then the new value next cycle.
- Scoreboard: reserve r3 → rd_busy=1 and pend_cnt=1. Reserve r3 and write r3 in the same cycle → still busy, pend_cnt=1. Write r3 alone → busy=0, pend_cnt=0.
- Reserve r1, r2, r4, then assert reset mid-RUN: next edge pend_cnt=0, ready=0, and the sweep restarts. A wr_en issued during the sweep has no effect (r9 reads 0 after ready).

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared types and width defaults for the regfile_sb register file.
package regfile_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_READ = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Low bit of port k's field in a flattened multi-port bus.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard: one bit per register plus a running count of set bits.
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_run,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic                   i_rsv_en,
    input  logic [ADDR_W-1:0]      i_rsv_addr,
    output logic [2**ADDR_W-1:0]   o_pending,
    output logic [ADDR_W:0]        o_pend_cnt
);

    logic [2**ADDR_W-1:0] r_pending;
    logic [ADDR_W:0]      r_cnt;
    logic                 w_wr;
    logic                 w_rsv;
    logic                 w_inc;
    logic                 w_dec;

    assign w_wr  = i_run && i_wr_en  && (i_wr_addr  != '0);
    assign w_rsv = i_run && i_rsv_en && (i_rsv_addr != '0);

    // A same-address reserve keeps the bit set, so the write must not decrement.
    assign w_inc = w_rsv && !r_pending[i_rsv_addr];
    assign w_dec = w_wr && r_pending[i_wr_addr] && !(w_rsv && (i_rsv_addr == i_wr_addr));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_wr)
                r_pending[i_wr_addr] <= 1'b0;
            if (w_rsv)
                r_pending[i_rsv_addr] <= 1'b1;
            if (w_inc && !w_dec)
                r_cnt <= r_cnt + 1'b1;
            else if (w_dec && !w_inc)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_pending  = r_pending;
    assign o_pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write port, optional write bypass
// and a pending scoreboard; storage is zeroed by a sweep after reset.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int BYPASS   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   o_rd_data,
    output logic [NUM_READ-1:0]          o_rd_busy,
    input  logic                         i_wr_en,
    input  logic [ADDR_W-1:0]            i_wr_addr,
    input  logic [DATA_W-1:0]            i_wr_data,
    input  logic                         i_rsv_en,
    input  logic [ADDR_W-1:0]            i_rsv_addr,
    output logic                         o_ready,
    output logic [ADDR_W:0]              o_pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_ready;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    w_pending;
    logic                w_run;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_din;

    assign w_run = (r_state == RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == '1) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: r_ready <= 1'b1;
                default: r_state <= CLEAR;
            endcase
        end
    end

    // The sweep and the external write share the single storage write port.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = i_wr_addr;
        w_mem_din  = i_wr_data;
        if (!reset) begin
            if (!w_run) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_ptr;
                w_mem_din  = '0;
            end else if (i_wr_en && (i_wr_addr != '0)) begin
                w_mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_din;
    end

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clock      (clock),
        .reset      (reset),
        .i_run      (w_run),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .o_pending  (w_pending),
        .o_pend_cnt (o_pend_cnt)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        logic              w_rsv_hit;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr    = i_rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
        assign w_hit     = (BYPASS != 0) && w_run && i_wr_en && (i_wr_addr == w_addr) && (w_addr != '0);
        assign w_rsv_hit = i_rsv_en && (i_rsv_addr == w_addr);

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_run && (w_addr != '0)) begin
                w_data = w_hit ? i_wr_data : r_mem[w_addr];
                w_busy = w_pending[w_addr] && !(w_hit && !w_rsv_hit);
            end
        end

        assign o_rd_data[slice_lo(k, DATA_W) +: DATA_W] = w_data;
        assign o_rd_busy[k] = w_busy;
    end

    assign o_ready = r_ready;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances against a behavioural register-file model.
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;

    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic             ready_b, ready_n;
    logic [AW:0]      pend_cnt_b, pend_cnt_n;

    int n_pass;
    int n_total;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_clear;
    int            m_sweep;

    always #5 clock = ~clock;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
        .o_rd_busy(rd_busy_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_ready(ready_b), .o_pend_cnt(pend_cnt_b)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n),
        .o_rd_busy(rd_busy_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_ready(ready_n), .o_pend_cnt(pend_cnt_n)
    );

    function automatic logic [NR*DW-1:0] exp_data(input bit byp);
        logic [NR*DW-1:0] v;
        logic [AW-1:0]    a;
        v = '0;
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            if (!m_clear && a != 0)
                v[k*DW +: DW] = (byp && wr_en && wr_addr == a) ? wr_data : m_mem[a];
        end
        return v;
    endfunction

    function automatic logic [NR-1:0] exp_busy(input bit byp);
        logic [NR-1:0] v;
        logic [AW-1:0] a;
        v = '0;
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            if (!m_clear && a != 0) begin
                if (byp && wr_en && wr_addr == a && !(rsv_en && rsv_addr == a))
                    v[k] = 1'b0;
                else
                    v[k] = m_pend[a];
            end
        end
        return v;
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int c;
        c = 0;
        for (int i = 0; i < DEPTH; i++)
            c += int'(m_pend[i]);
        return (AW+1)'(c);
    endfunction

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd_addr = {a1, a0};
        #1;
    endtask

    // One rising edge; the model applies the same edge from the inputs held across it.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            m_clear = 1'b1;
            m_sweep = 0;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        end else if (m_clear) begin
            m_mem[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == DEPTH) m_clear = 1'b0;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        drive(0, 0, 0, 0, 0, 3, 9);
        n_total++; if (ready_b !== 1'b0 || ready_n !== 1'b0) $display("FAIL reset_ready got %b/%b exp 0", ready_b, ready_n); else n_pass++;
        n_total++; if (pend_cnt_b !== '0) $display("FAIL reset_pend_cnt got %0d exp 0", pend_cnt_b); else n_pass++;
        n_total++; if (rd_busy_b !== '0 || rd_data_b !== '0) $display("FAIL reset_reads got %h busy %b exp 0", rd_data_b, rd_busy_b); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, AW'($urandom), $urandom, 1, AW'($urandom), AW'($urandom), AW'($urandom));
            n_total++;
            if (ready_b !== 1'b0 || rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0)
                $display("FAIL sweep_%0d ready %b data %h/%h busy %b exp ready 0 data 0 busy 0", i, ready_b, rd_data_b, rd_data_n, rd_busy_b);
            else n_pass++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 31);
        n_total++; if (ready_b !== 1'b1 || ready_n !== 1'b1) $display("FAIL ready_edge32 got %b/%b exp 1", ready_b, ready_n); else n_pass++;
        n_total++; if (pend_cnt_b !== '0 || rd_data_b !== '0) $display("FAIL after_sweep cnt %0d data %h exp 0", pend_cnt_b, rd_data_b); else n_pass++;
    endtask

    task automatic test_write();
        drive(1, 5, 32'hDEADBEEF, 0, 0, 1, 2);
        n_total++; if (rd_data_n !== '0) $display("FAIL write_no_bypass_early got %h exp 0", rd_data_n); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 5, 5);
        n_total++; if (rd_data_b !== {2{32'hDEADBEEF}} || rd_data_n !== {2{32'hDEADBEEF}})
            $display("FAIL write_r5 got %h/%h exp %h", rd_data_b, rd_data_n, {2{32'hDEADBEEF}}); else n_pass++;
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        n_total++; if (rd_data_b !== '0) $display("FAIL r0_bypass got %h exp 0", rd_data_b); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (rd_data_b !== '0 || rd_data_n !== '0) $display("FAIL r0_write got %h/%h exp 0", rd_data_b, rd_data_n); else n_pass++;
    endtask

    task automatic test_bypass();
        drive(1, 7, 32'h11111111, 0, 0, 0, 0);
        tick();
        drive(1, 7, 32'h12345678, 0, 0, 5, 7);
        n_total++; if (rd_data_b[63:32] !== 32'h12345678) $display("FAIL bypass_on got %h exp 12345678", rd_data_b[63:32]); else n_pass++;
        n_total++; if (rd_data_n[63:32] !== 32'h11111111) $display("FAIL bypass_off got %h exp 11111111", rd_data_n[63:32]); else n_pass++;
        n_total++; if (rd_data_b[31:0] !== 32'hDEADBEEF) $display("FAIL bypass_other_port got %h exp deadbeef", rd_data_b[31:0]); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 5, 7);
        n_total++; if (rd_data_n[63:32] !== 32'h12345678) $display("FAIL bypass_off_next got %h exp 12345678", rd_data_n[63:32]); else n_pass++;
    endtask

    task automatic test_scoreboard();
        drive(0, 0, 0, 1, 3, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        n_total++; if (rd_busy_b[0] !== 1'b1 || pend_cnt_b !== 6'd1) $display("FAIL rsv_r3 busy %b cnt %0d exp 1 1", rd_busy_b[0], pend_cnt_b); else n_pass++;
        drive(1, 3, 32'hAAAA0003, 1, 3, 3, 0);
        n_total++; if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1) $display("FAIL rsv_wr_same_busy got %b/%b exp 1", rd_busy_b[0], rd_busy_n[0]); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        n_total++; if (rd_busy_b[0] !== 1'b1 || pend_cnt_b !== 6'd1 || rd_data_b[31:0] !== 32'hAAAA0003)
            $display("FAIL rsv_wr_after busy %b cnt %0d data %h exp 1 1 aaaa0003", rd_busy_b[0], pend_cnt_b, rd_data_b[31:0]); else n_pass++;
        drive(1, 3, 32'h0000000B, 0, 0, 3, 0);
        n_total++; if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b1) $display("FAIL wr_busy_bypass got %b/%b exp 0/1", rd_busy_b[0], rd_busy_n[0]); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        n_total++; if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b0 || pend_cnt_b !== '0 || pend_cnt_n !== '0)
            $display("FAIL wr_clears busy %b/%b cnt %0d/%0d exp 0", rd_busy_b[0], rd_busy_n[0], pend_cnt_b, pend_cnt_n); else n_pass++;
    endtask

    task automatic test_random();
        logic [AW-1:0] a0, a1;
        for (int i = 0; i < 400; i++) begin
            a0 = (i % 5 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            a1 = AW'($urandom_range(0, 7));
            drive(1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), a0, a1);
            n_total++;
            if (rd_data_b !== exp_data(1) || rd_data_n !== exp_data(0))
                $display("FAIL rand_data_%0d got %h/%h exp %h/%h", i, rd_data_b, rd_data_n, exp_data(1), exp_data(0));
            else n_pass++;
            n_total++;
            if (rd_busy_b !== exp_busy(1) || rd_busy_n !== exp_busy(0))
                $display("FAIL rand_busy_%0d got %b/%b exp %b/%b", i, rd_busy_b, rd_busy_n, exp_busy(1), exp_busy(0));
            else n_pass++;
            tick();
            n_total++;
            if (pend_cnt_b !== exp_cnt() || pend_cnt_n !== exp_cnt())
                $display("FAIL rand_cnt_%0d got %0d/%0d exp %0d", i, pend_cnt_b, pend_cnt_n, exp_cnt());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 1; i < DEPTH; i++) begin
            drive(1, AW'(i), 32'(i), 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 2, 0, 0); tick();
        drive(0, 0, 0, 1, 4, 1, 4);
        tick();
        drive(0, 0, 0, 0, 0, 1, 4);
        n_total++; if (pend_cnt_b !== 6'd3 || rd_busy_b !== 2'b11) $display("FAIL pre_reset cnt %0d busy %b exp 3 11", pend_cnt_b, rd_busy_b); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 4);
        n_total++; if (pend_cnt_b !== '0 || ready_b !== 1'b0 || rd_busy_b !== '0 || rd_data_b !== '0)
            $display("FAIL mid_reset cnt %0d ready %b busy %b data %h exp 0", pend_cnt_b, ready_b, rd_busy_b, rd_data_b); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 9, 32'h99999999, 1, 9, 9, 4);
            n_total++; if (ready_b !== 1'b0) $display("FAIL resweep_ready_%0d got %b exp 0", i, ready_b); else n_pass++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 9, 4);
        n_total++; if (ready_b !== 1'b1 || rd_data_b !== '0 || rd_busy_b !== '0 || pend_cnt_b !== '0)
            $display("FAIL r9_after_sweep ready %b data %h busy %b cnt %0d exp 1 0 0 0", ready_b, rd_data_b, rd_busy_b, pend_cnt_b); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_clear = 1'b1;
        m_sweep = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
